// File: rtl/alice4_pkg.sv
// Shared alice4 definitions: bus widths, master ids, arbiter state encodings
// and the pending-read tracking entry.
package alice4_pkg;

  localparam int ADDR_W = 29;
  localparam int DATA_W = 64;
  localparam int BE_W   = 8;
  localparam int BC_W   = 8;

  localparam logic MASTER_M0 = 1'b0;
  localparam logic MASTER_M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_M0 = 2'd1,
    GRANT_M1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [BC_W-1:0]   burstcount;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
  } cmd_t;

  typedef struct packed {
    logic            id;
    logic [BC_W-1:0] burst;
  } pend_entry_t;

  // A burstcount of zero on the bus still moves one beat.
  function automatic logic [BC_W-1:0] eff_burst(input logic [BC_W-1:0] bc);
    return (bc == '0) ? BC_W'(1) : bc;
  endfunction

endpackage

// File: rtl/memory_arbiter_pending_fifo.sv
// Synchronous FIFO of outstanding read commands ({master id, burstcount}),
// head is visible combinationally so responses can be routed in order.
module pending_fifo
  import alice4_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  pend_entry_t push_data,
  input  logic        pop,
  output pend_entry_t head,
  output logic        full,
  output logic        empty,
  output logic [5:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pend_entry_t      mem_q [DEPTH];
  pend_entry_t      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [5:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == 6'(DEPTH));
  assign empty   = (count_q == 6'd0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 6'd1;
      2'b01:   count_d = count_q - 6'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-master SDRAM arbiter: M0 (scan-out) has priority with a fairness cap,
// M1 (rasterizer) is low priority; read data is routed back in command order.
module memory_arbiter
  import alice4_pkg::*;
#(
  parameter int MAX_PENDING = 8,
  parameter int FAIR_LIMIT  = 16
) (
  input  logic              clock,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BC_W-1:0]   m0_burstcount,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic              m0_readdatavalid,
  output logic [DATA_W-1:0] m0_readdata,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BC_W-1:0]   m1_burstcount,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic              m1_readdatavalid,
  output logic [DATA_W-1:0] m1_readdata,

  output logic [ADDR_W-1:0] s_address,
  output logic [BC_W-1:0]   s_burstcount,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic              s_waitrequest,
  input  logic              s_readdatavalid,
  input  logic [DATA_W-1:0] s_readdata,

  output logic [5:0]        pending_count
);

  localparam int FAIR_W = (FAIR_LIMIT > 0) ? $clog2(FAIR_LIMIT + 1) : 1;

  arb_state_e        state_q, state_d;
  logic [FAIR_W-1:0] fair_cnt_q, fair_cnt_d;
  logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic              burst_active_q, burst_active_d;
  logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;

  cmd_t        m0_cmd, m1_cmd, sel_cmd;
  logic        grant_m0, grant_m1;
  logic        m0_req, m1_req;
  logic        read_block, grant_wait;
  logic        read_accept, write_accept;
  logic        fifo_full, fifo_empty, fifo_pop;
  pend_entry_t fifo_head, fifo_push_data;
  logic        rsp_valid, last_beat;

  assign m0_cmd = '{address: m0_address, burstcount: m0_burstcount, read: m0_read,
                    write: m0_write, writedata: m0_writedata, byteenable: m0_byteenable};
  assign m1_cmd = '{address: m1_address, burstcount: m1_burstcount, read: m1_read,
                    write: m1_write, writedata: m1_writedata, byteenable: m1_byteenable};

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

  // Grants are masked by reset so the bus is quiet during the reset cycle itself.
  assign grant_m0 = (state_q == GRANT_M0) && !reset;
  assign grant_m1 = (state_q == GRANT_M1) && !reset;

  always_comb begin
    sel_cmd = '0;
    if (grant_m0) begin
      sel_cmd = m0_cmd;
    end else if (grant_m1) begin
      sel_cmd = m1_cmd;
    end
    read_block     = sel_cmd.read & fifo_full;
    grant_wait     = s_waitrequest | read_block;
    s_address      = sel_cmd.address;
    s_burstcount   = sel_cmd.burstcount;
    s_read         = sel_cmd.read & ~read_block;
    s_write        = sel_cmd.write;
    s_writedata    = sel_cmd.writedata;
    s_byteenable   = sel_cmd.byteenable;
    m0_waitrequest = grant_m0 ? grant_wait : 1'b1;
    m1_waitrequest = grant_m1 ? grant_wait : 1'b1;
  end

  assign read_accept  = s_read & ~s_waitrequest;
  assign write_accept = s_write & ~s_waitrequest & ~sel_cmd.read;

  // Arbitration, fairness counting and write-burst tracking.
  always_comb begin
    state_d        = state_q;
    fair_cnt_d     = fair_cnt_q;
    burst_cnt_d    = burst_cnt_q;
    burst_active_d = burst_active_q;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          if (fair_cnt_q == FAIR_W'(FAIR_LIMIT)) begin
            state_d    = GRANT_M1;
            fair_cnt_d = '0;
          end else begin
            state_d    = GRANT_M0;
            fair_cnt_d = fair_cnt_q + FAIR_W'(1);
          end
        end else if (m0_req) begin
          state_d = GRANT_M0;
        end else if (m1_req) begin
          state_d    = GRANT_M1;
          fair_cnt_d = '0;
        end
      end
      GRANT_M0, GRANT_M1: begin
        if (read_accept) begin
          state_d = IDLE;
        end else if (write_accept) begin
          if (!burst_active_q) begin
            if (eff_burst(sel_cmd.burstcount) == BC_W'(1)) begin
              state_d = IDLE;
            end else begin
              burst_active_d = 1'b1;
              burst_cnt_d    = eff_burst(sel_cmd.burstcount) - BC_W'(1);
            end
          end else if (burst_cnt_q == BC_W'(1)) begin
            state_d        = IDLE;
            burst_active_d = 1'b0;
            burst_cnt_d    = '0;
          end else begin
            burst_cnt_d = burst_cnt_q - BC_W'(1);
          end
        end else if (!burst_active_q && !sel_cmd.read && !sel_cmd.write) begin
          // A master that withdraws its request must not hold the bus.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_push_data = '{id: grant_m1 ? MASTER_M1 : MASTER_M0, burst: sel_cmd.burstcount};

  pending_fifo #(
    .DEPTH(MAX_PENDING)
  ) u_pending_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (read_accept),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (pending_count)
  );

  // Beats with nothing outstanding are dropped without touching any state.
  always_comb begin
    rsp_valid  = s_readdatavalid & ~fifo_empty & ~reset;
    last_beat  = (beat_cnt_q + BC_W'(1)) == eff_burst(fifo_head.burst);
    fifo_pop   = rsp_valid & last_beat;
    beat_cnt_d = beat_cnt_q;
    if (rsp_valid) begin
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + BC_W'(1);
    end
  end

  assign m0_readdatavalid = rsp_valid & (fifo_head.id == MASTER_M0);
  assign m1_readdatavalid = rsp_valid & (fifo_head.id == MASTER_M1);
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      fair_cnt_q     <= '0;
      burst_cnt_q    <= '0;
      burst_active_q <= 1'b0;
      beat_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      fair_cnt_q     <= fair_cnt_d;
      burst_cnt_q    <= burst_cnt_d;
      burst_active_q <= burst_active_d;
      beat_cnt_q     <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter; read responses are checked against a
// scoreboard queue filled as read commands are issued.
module tb_memory_arbiter;
  import alice4_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] m0_address, m1_address, s_address;
  logic [BC_W-1:0]   m0_burstcount, m1_burstcount, s_burstcount;
  logic              m0_read, m0_write, m1_read, m1_write, s_read, s_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable, s_byteenable;
  logic              m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
  logic              s_waitrequest, s_readdatavalid;
  logic [5:0]        pending_count;

  typedef struct {
    logic        id;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  memory_arbiter #(.MAX_PENDING(8), .FAIR_LIMIT(16)) dut (
    .clock(clock), .reset(reset),
    .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest),
    .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata),
    .pending_count(pending_count)
  );

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_exp(input logic id, input logic [63:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic apply_idle();
    m0_address = '0; m0_burstcount = '0; m0_read = 1'b0; m0_write = 1'b0;
    m0_writedata = '0; m0_byteenable = 8'hFF;
    m1_address = '0; m1_burstcount = '0; m1_read = 1'b0; m1_write = 1'b0;
    m1_writedata = '0; m1_byteenable = 8'hFF;
  endtask

  // Response monitor: every valid beat must match the oldest expected entry.
  always @(negedge clock) begin
    if (m0_readdatavalid || m1_readdatavalid) begin
      if (sb.size() == 0) begin
        check_output("unexpected_rdv", {62'b0, m1_readdatavalid, m0_readdatavalid}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check_output("rdv_route", {62'b0, m1_readdatavalid, m0_readdatavalid},
                     mon_e.id ? 64'd2 : 64'd1);
        check_output("rdv_data_m0", m0_readdata, mon_e.data);
        check_output("rdv_data_m1", m1_readdata, mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic grant_id [34];
    int   n;
    int   beats;
    int   nacc;
    logic accepted;
    logic found;
    logic m0_grant_seen;
    int   m0_first;
    int   m0_second;

    reset = 1'b1;
    apply_idle();
    s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;
    tick();
    tick();
    check_output("rst_s_read", s_read, 0);
    check_output("rst_s_write", s_write, 0);
    check_output("rst_s_address", s_address, 0);
    check_output("rst_m0_wait", m0_waitrequest, 1);
    check_output("rst_m1_wait", m1_waitrequest, 1);
    check_output("rst_pending", pending_count, 0);
    reset = 1'b0;
    tick();

    $display("[TB] simultaneous reads");
    m0_read = 1'b1; m0_address = 29'h100; m0_burstcount = 8'd1;
    m1_read = 1'b1; m1_address = 29'h200; m1_burstcount = 8'd1;
    push_exp(MASTER_M0, 64'hD0D0_0000_0000_0001);
    push_exp(MASTER_M1, 64'hD1D1_0000_0000_0002);
    settle();
    check_output("idle_no_s_read", s_read, 0);
    tick();
    check_output("m0_first_wait", m0_waitrequest, 0);
    check_output("m1_held_wait", m1_waitrequest, 1);
    check_output("m0_addr_out", s_address, 29'h100);
    check_output("m0_s_read", s_read, 1);
    tick();
    m0_read = 1'b0;
    settle();
    check_output("pending_one", pending_count, 1);
    tick();
    check_output("m1_second_wait", m1_waitrequest, 0);
    check_output("m1_addr_out", s_address, 29'h200);
    tick();
    m1_read = 1'b0;
    settle();
    check_output("pending_two", pending_count, 2);
    s_readdatavalid = 1'b1; s_readdata = 64'hD0D0_0000_0000_0001;
    tick();
    s_readdata = 64'hD1D1_0000_0000_0002;
    tick();
    s_readdatavalid = 1'b0; s_readdata = '0;
    settle();
    check_output("pending_drained", pending_count, 0);
    check_output("sb_drained_1", sb.size(), 0);

    $display("[TB] fairness");
    m0_write = 1'b1; m0_burstcount = 8'd1; m0_address = 29'h10;
    m1_write = 1'b1; m1_burstcount = 8'd1; m1_address = 29'h20;
    n = 0;
    for (int cyc = 0; cyc < 100 && n < 34; cyc++) begin
      settle();
      if (!m0_waitrequest) begin
        grant_id[n] = MASTER_M0; n++;
      end else if (!m1_waitrequest) begin
        grant_id[n] = MASTER_M1; n++;
      end
      tick();
    end
    apply_idle();
    check_output("fair_grant_count", n, 34);
    m0_first = 0; m0_second = 0;
    for (int i = 0; i < 16; i++) begin
      if (n == 34 && grant_id[i] == MASTER_M0) m0_first++;
      if (n == 34 && grant_id[17 + i] == MASTER_M0) m0_second++;
    end
    check_output("fair_first_16_m0", m0_first, 16);
    check_output("fair_17th_m1", (n == 34) ? grant_id[16] : 1'bx, MASTER_M1);
    check_output("fair_cnt_cleared", m0_second, 16);
    check_output("fair_34th_m1", (n == 34) ? grant_id[33] : 1'bx, MASTER_M1);
    tick();
    tick();

    $display("[TB] write burst");
    m1_write = 1'b1; m1_burstcount = 8'd4; m1_address = 29'h300; m1_writedata = 64'hA000;
    beats = 0; m0_grant_seen = 1'b0;
    for (int cyc = 0; cyc < 40 && beats < 4; cyc++) begin
      s_waitrequest = cyc[0];
      if (cyc == 3) begin
        m0_read = 1'b1; m0_address = 29'h400; m0_burstcount = 8'd1;
        push_exp(MASTER_M0, 64'hD2D2_0000_0000_0003);
      end
      settle();
      if (!m0_waitrequest) m0_grant_seen = 1'b1;
      accepted = m1_write && !m1_waitrequest;
      if (accepted) begin
        check_output("burst_s_write", s_write, 1);
        check_output("burst_beat_data", s_writedata, 64'hA000 + 64'(beats));
        beats++;
      end
      tick();
      if (accepted) begin
        if (beats == 4) m1_write = 1'b0;
        else m1_writedata = 64'hA000 + 64'(beats);
      end
    end
    s_waitrequest = 1'b0;
    check_output("burst_beat_count", beats, 4);
    check_output("m0_blocked_in_burst", m0_grant_seen, 0);
    found = 1'b0;
    for (int cyc = 0; cyc < 5 && !found; cyc++) begin
      settle();
      if (!m0_waitrequest) found = 1'b1;
      tick();
    end
    m0_read = 1'b0;
    check_output("m0_after_burst", found, 1);
    s_readdatavalid = 1'b1; s_readdata = 64'hD2D2_0000_0000_0003;
    tick();
    s_readdatavalid = 1'b0;
    settle();
    check_output("pending_after_burst", pending_count, 0);

    $display("[TB] fifo full");
    m0_read = 1'b1; m0_burstcount = 8'd1;
    nacc = 0;
    for (int cyc = 0; cyc < 60 && nacc < 8; cyc++) begin
      m0_address = 29'h500 + 29'(nacc);
      settle();
      if (!m0_waitrequest) begin
        push_exp(MASTER_M0, 64'hB000 + 64'(nacc));
        nacc++;
      end
      tick();
    end
    m0_address = 29'h508;
    tick();
    tick();
    settle();
    check_output("full_pending", pending_count, 8);
    check_output("full_s_read_held", s_read, 0);
    check_output("full_m0_wait", m0_waitrequest, 1);
    s_readdatavalid = 1'b1; s_readdata = 64'hB000;
    tick();
    s_readdatavalid = 1'b0;
    settle();
    check_output("ninth_s_read", s_read, 1);
    check_output("ninth_m0_wait", m0_waitrequest, 0);
    push_exp(MASTER_M0, 64'hB008);
    tick();
    m0_read = 1'b0;
    settle();
    check_output("pending_after_ninth", pending_count, 8);
    s_readdatavalid = 1'b1; s_readdata = 64'hB001;
    tick();
    s_readdatavalid = 1'b0;
    m0_read = 1'b1; m0_address = 29'h509;
    found = 1'b0;
    for (int cyc = 0; cyc < 5 && !found; cyc++) begin
      settle();
      if (!m0_waitrequest) begin
        found = 1'b1;
        s_readdatavalid = 1'b1; s_readdata = 64'hB002;
        push_exp(MASTER_M0, 64'hB009);
      end
      tick();
    end
    s_readdatavalid = 1'b0; m0_read = 1'b0;
    settle();
    check_output("push_pop_granted", found, 1);
    check_output("push_pop_same_cycle", pending_count, 7);
    s_readdatavalid = 1'b1;
    for (int i = 3; i <= 9; i++) begin
      s_readdata = 64'hB000 + 64'(i);
      tick();
    end
    s_readdatavalid = 1'b0;
    settle();
    check_output("pending_after_drain", pending_count, 0);
    check_output("sb_drained_2", sb.size(), 0);

    $display("[TB] spurious beats and reset");
    s_readdatavalid = 1'b1; s_readdata = 64'hDEAD;
    settle();
    check_output("spurious_m0_rdv", m0_readdatavalid, 0);
    check_output("spurious_m1_rdv", m1_readdatavalid, 0);
    tick();
    tick();
    s_readdatavalid = 1'b0;
    settle();
    check_output("spurious_pending", pending_count, 0);
    m1_read = 1'b1; m1_address = 29'h600; m1_burstcount = 8'd4;
    found = 1'b0;
    for (int cyc = 0; cyc < 5 && !found; cyc++) begin
      settle();
      if (!m1_waitrequest) found = 1'b1;
      tick();
    end
    m1_read = 1'b0;
    settle();
    check_output("burst_read_pending", pending_count, 1);
    push_exp(MASTER_M1, 64'hC000);
    push_exp(MASTER_M1, 64'hC001);
    s_readdatavalid = 1'b1; s_readdata = 64'hC000;
    tick();
    s_readdata = 64'hC001;
    tick();
    reset = 1'b1; s_readdata = 64'hC002;
    settle();
    check_output("rdv_in_reset", m1_readdatavalid, 0);
    tick();
    reset = 1'b0; s_readdata = 64'hC003;
    settle();
    check_output("rdv_after_reset_m1", m1_readdatavalid, 0);
    check_output("rdv_after_reset_m0", m0_readdatavalid, 0);
    check_output("pending_after_reset", pending_count, 0);
    tick();
    s_readdatavalid = 1'b0;
    settle();
    check_output("post_reset_s_read", s_read, 0);
    check_output("post_reset_m1_wait", m1_waitrequest, 1);
    m0_write = 1'b1; m0_burstcount = 8'd1; m0_address = 29'h700;
    settle();
    check_output("post_reset_idle", m0_waitrequest, 1);
    tick();
    check_output("post_reset_grant", m0_waitrequest, 0);
    tick();
    m0_write = 1'b0;
    tick();
    check_output("sb_final", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
